// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: shared bus widths and ROM control encodings for the fetch front end
package if_fetch_unit_pkg;
  localparam int          INST_ADDR_BUS   = 32;
  localparam int          INST_BUS        = 32;
  localparam logic [31:0] ZERO_WORD       = 32'h0000_0000;
  localparam logic [31:0] START_INST_ADDR = 32'h0000_0000;
  localparam logic        CHIP_ENABLE     = 1'b1;
  localparam logic        CHIP_DISABLE    = 1'b0;
endpackage

// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if: ROM, redirect and IF/ID handshake bundle around the fetch unit
interface if_fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);
  logic              rom_ce;
  logic [ADDR_W-1:0] rom_addr;
  logic [INST_W-1:0] rom_inst;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              id_valid;
  logic              id_ready;
  logic [ADDR_W-1:0] id_pc;
  logic [INST_W-1:0] id_inst;
  logic              misalign_err;
  modport master (
    output rom_ce, rom_addr, id_valid, id_pc, id_inst, misalign_err,
    input  rom_inst, redirect_valid, redirect_pc, id_ready
  );
  modport slave (
    input  rom_ce, rom_addr, id_valid, id_pc, id_inst, misalign_err,
    output rom_inst, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/if_fetch_unit_fetch_fifo.sv
// fetch_fifo: synchronous prefetch queue with flush; head reads as zero when empty
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  always_comb begin
    wr_d  = flush ? '0 : wr_q + AW'(push);
    rd_d  = flush ? '0 : rd_q + AW'(pop);
    cnt_d = flush ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_q] <= wdata;
  end
  assign full  = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign rdata = empty ? '0 : mem[rd_q];
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: owns the fetch PC, drives the ROM and queues {pc, inst} pairs toward IF/ID
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W     = INST_ADDR_BUS,
  parameter int                INST_W     = INST_BUS,
  parameter logic [ADDR_W-1:0] RESET_PC   = START_INST_ADDR,
  parameter int                FIFO_DEPTH = 4
) (
  input logic          clk,
  input logic          rst,
  if_fetch_unit_if.master bus
);
  logic                     started_q, started_d, misalign_q, misalign_d;
  logic [ADDR_W-1:0]        pc_q, pc_d;
  logic                     full, empty, valid, pop, fetch;
  logic [ADDR_W+INST_W-1:0] head;
  // A redirect squashes both ends of the queue in its cycle so stale work never escapes
  always_comb begin
    valid      = ~empty & ~bus.redirect_valid;
    pop        = valid & bus.id_ready;
    fetch      = started_q & ~bus.redirect_valid & (~full | pop);
    pc_d       = bus.redirect_valid ? {bus.redirect_pc[ADDR_W-1:2], 2'b00}
               : fetch ? pc_q + ADDR_W'(4) : pc_q;
    started_d  = 1'b1;
    misalign_d = bus.redirect_valid & |bus.redirect_pc[1:0];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      started_q  <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      started_q  <= started_d;
      misalign_q <= misalign_d;
    end
  end
  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ADDR_W+INST_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (fetch),
    .pop   (pop),
    .flush (bus.redirect_valid),
    .wdata ({pc_q, bus.rom_inst}),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );
  assign bus.rom_ce                 = fetch ? CHIP_ENABLE : CHIP_DISABLE;
  assign bus.rom_addr               = pc_q;
  assign bus.id_valid               = valid;
  assign {bus.id_pc, bus.id_inst}   = head;
  assign bus.misalign_err           = misalign_q;
endmodule
